// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and constants for the scan sequencer
//
// Purpose : FSM state encoding and channel-count constants used by the
//           scan sequencer, its interface and the channel-select helper.
// Ports   : none (package).
// Config  : SCAN_MASK_EN (consumed by the importing files).
package scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/scan_sequencer_if.sv
// rtl/scan_sequencer_if.sv - control/status bundle between host and scan sequencer
//
// Purpose : groups the scan request inputs and the decoder-facing outputs.
// Signals : start, stop, continuous, dwell[DWELL_W], ch_mask[8] (SCAN_MASK_EN
//           only) from the host; sel[3], sel_valid, busy, done, wrap from the
//           sequencer.
// Modports: master = host side, slave = sequencer side.
// Config  : SCAN_MASK_EN adds ch_mask.
interface scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  import scan_pkg::*;

  logic               start;
  logic               stop;
  logic               continuous;
  logic [DWELL_W-1:0] dwell;
`ifdef SCAN_MASK_EN
  logic [NUM_CH-1:0]  ch_mask;
`endif
  logic [SEL_W-1:0]   sel;
  logic               sel_valid;
  logic               busy;
  logic               done;
  logic               wrap;

  modport master (
    output start, stop, continuous, dwell,
`ifdef SCAN_MASK_EN
    output ch_mask,
`endif
    input  sel, sel_valid, busy, done, wrap
  );

  modport slave (
    input  start, stop, continuous, dwell,
`ifdef SCAN_MASK_EN
    input  ch_mask,
`endif
    output sel, sel_valid, busy, done, wrap
  );

endinterface

// File: rtl/scan_next_ch.sv
// rtl/scan_next_ch.sv - combinational next/first/last channel finder
//
// Purpose : given the channel-enable mask and the current index, returns the
//           next higher enabled index, the lowest enabled index and whether
//           the current index is the last enabled one.
// Ports   : i_mask[8] (SCAN_MASK_EN only), i_cur[3] in;
//           o_next[3], o_first[3], o_is_last out.
// Config  : without SCAN_MASK_EN all channels are enabled and this reduces to
//           a plain increment.
module scan_next_ch
  import scan_pkg::*;
(
`ifdef SCAN_MASK_EN
  input  logic [NUM_CH-1:0] i_mask,
`endif
  input  logic [SEL_W-1:0]  i_cur,
  output logic [SEL_W-1:0]  o_next,
  output logic [SEL_W-1:0]  o_first,
  output logic              o_is_last
);

`ifdef SCAN_MASK_EN
  // Both searches run high-to-low so the final assignment is the lowest match.
  always_comb begin
    o_next    = i_cur;
    o_first   = '0;
    o_is_last = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_first = SEL_W'(i);
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i > int'(i_cur))) begin
        o_next    = SEL_W'(i);
        o_is_last = 1'b0;
      end
    end
  end
`else
  // 7 + 1 wraps to 0 through natural 3-bit overflow.
  always_comb begin
    o_next    = i_cur + SEL_W'(1);
    o_first   = '0;
    o_is_last = (i_cur == SEL_W'(NUM_CH - 1));
  end
`endif

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - channel scan sequencer driving the 3-to-8 decoder select
//
// Purpose : on start, steps sel through the enabled channels holding each for
//           dwell+1 cycles; single pass (done pulse) or continuous (wrap pulse).
// Ports   : i_clk, i_rst_n (async active-low); bus (scan_sequencer_if.slave)
//           carrying start/stop/continuous/dwell[/ch_mask] and
//           sel/sel_valid/busy/done/wrap.
// Config  : SCAN_MASK_EN enables ch_mask-based channel skipping.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  scan_sequencer_if.slave bus
);

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic               r_sel_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_wrap;
  logic               r_cont;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_cnt;

  logic [SEL_W-1:0]   w_next;
  logic [SEL_W-1:0]   w_first;
  logic               w_is_last;
  logic               w_any;

`ifdef SCAN_MASK_EN
  logic [NUM_CH-1:0]  r_mask;
  logic [NUM_CH-1:0]  w_mask;

  // In IDLE the finder looks at the live mask so the first channel can be
  // loaded on the start edge; during SCAN it uses the captured copy.
  assign w_mask = (r_state == IDLE) ? bus.ch_mask : r_mask;
  assign w_any  = |bus.ch_mask;

  scan_next_ch u_next_ch (
    .i_mask    (w_mask),
    .i_cur     (r_sel),
    .o_next    (w_next),
    .o_first   (w_first),
    .o_is_last (w_is_last)
  );
`else
  assign w_any = 1'b1;

  scan_next_ch u_next_ch (
    .i_cur     (r_sel),
    .o_next    (w_next),
    .o_first   (w_first),
    .o_is_last (w_is_last)
  );
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wrap      <= 1'b0;
      r_cont      <= 1'b0;
      r_dwell     <= '0;
      r_cnt       <= '0;
`ifdef SCAN_MASK_EN
      r_mask      <= '0;
`endif
    end else begin
      // Pulses default low; set only on the cycle they apply.
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sel       <= '0;
          r_sel_valid <= 1'b0;
          r_busy      <= 1'b0;
          if (bus.start && !bus.stop && w_any) begin
            r_state     <= SCAN;
            r_cont      <= bus.continuous;
            r_dwell     <= bus.dwell;
            r_cnt       <= bus.dwell;
            r_sel       <= w_first;
            r_sel_valid <= 1'b1;
            r_busy      <= 1'b1;
`ifdef SCAN_MASK_EN
            r_mask      <= bus.ch_mask;
`endif
          end
        end
        SCAN: begin
          if (bus.stop) begin
            // Abort suppresses done/wrap even on the final dwell cycle.
            r_state     <= IDLE;
            r_sel       <= '0;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DWELL_W'(1);
          end else if (!w_is_last) begin
            r_sel <= w_next;
            r_cnt <= r_dwell;
          end else if (r_cont) begin
            r_sel  <= w_first;
            r_cnt  <= r_dwell;
            r_wrap <= 1'b1;
          end else begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sel       = r_sel;
  assign bus.sel_valid = r_sel_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - directed self-checking bench for scan_sequencer
//
// Purpose : drives reset, single-pass, continuous, stop, start/stop clash,
//           mid-scan changes and maximum dwell; mask cases with SCAN_MASK_EN.
// Ports   : none (top-level bench).
// Config  : SCAN_MASK_EN enables the channel-mask steps.
module tb_scan_sequencer;
  import scan_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  scan_sequencer_if #(.DWELL_W(8)) bus ();

  scan_sequencer #(.DWELL_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] sel, input logic vld,
                         input logic bsy, input logic dn, input logic wr);
    chk({tag, ".sel"},       32'(bus.sel),       32'(sel));
    chk({tag, ".sel_valid"}, 32'(bus.sel_valid), 32'(vld));
    chk({tag, ".busy"},      32'(bus.busy),      32'(bsy));
    chk({tag, ".done"},      32'(bus.done),      32'(dn));
    chk({tag, ".wrap"},      32'(bus.wrap),      32'(wr));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.continuous = 1'b0;
    bus.dwell      = 8'd0;
`ifdef SCAN_MASK_EN
    bus.ch_mask    = 8'hFF;
`endif
    step();
    step();
    chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_all("idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-scan at sel = 5
    bus.continuous = 1'b1;
    bus.dwell      = 8'd0;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    chk("rst_mid.pre_sel", 32'(bus.sel), 32'd5);
    rst_n = 1'b0;
    #1;
    chk_all("rst_mid.async", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    step();
    chk_all("rst_mid.after", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single pass dwell=2, with start/dwell/continuous disturbed mid-scan
    bus.continuous = 1'b0;
    bus.dwell      = 8'd2;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    for (int ch = 0; ch < 8; ch++) begin
      for (int k = 0; k < 3; k++) begin
        chk_all($sformatf("single.ch%0d.k%0d", ch, k), 3'(ch), 1'b1, 1'b1, 1'b0, 1'b0);
        if (ch == 3 && k == 0) begin
          bus.start      = 1'b1;
          bus.dwell      = 8'd0;
          bus.continuous = 1'b1;
        end
        if (ch == 3 && k == 1) bus.start = 1'b0;
        step();
      end
    end
    chk_all("single.end", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("single.after", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Continuous dwell=0, stop at sel=3
    bus.continuous = 1'b1;
    bus.dwell      = 8'd0;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk_all($sformatf("cont.c%0d", c), 3'(c % 8), 1'b1, 1'b1, 1'b0,
              (c % 8 == 0) && (c != 0));
      if (c < 19) step();
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_all("cont.stop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("cont.stop2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stop coinciding with last channel of a single pass: no done
    bus.continuous = 1'b0;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (7) step();
    chk("stop_last.sel", 32'(bus.sel), 32'd7);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_all("stop_last.a", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("stop_last.b", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // start and stop together in IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    chk_all("clash.a", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk_all("clash.b", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Maximum dwell: each channel held 256 cycles
    bus.continuous = 1'b0;
    bus.dwell      = 8'hFF;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    for (int ch = 0; ch < 8; ch++) begin
      for (int k = 0; k < 256; k++) begin
        if (k == 0 || k == 255)
          chk_all($sformatf("maxdw.ch%0d.k%0d", ch, k), 3'(ch), 1'b1, 1'b1, 1'b0, 1'b0);
        else
          chk($sformatf("maxdw.ch%0d.k%0d.sel", ch, k), 32'(bus.sel), 32'(ch));
        step();
      end
    end
    chk_all("maxdw.end", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SCAN_MASK_EN
    // Mask 1010_0100, dwell=1: channels 2,5,7 for 2 cycles each
    bus.ch_mask    = 8'b1010_0100;
    bus.dwell      = 8'd1;
    bus.continuous = 1'b0;
    bus.start      = 1'b1;
    step();
    bus.start   = 1'b0;
    bus.ch_mask = 8'hFF;
    chk_all("mask.2a", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("mask.2b", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("mask.5a", 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("mask.5b", 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("mask.7a", 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("mask.7b", 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("mask.done", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Empty mask: start ignored
    bus.ch_mask = 8'h00;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    chk_all("mask.empty", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single channel continuous: wrap every dwell+1 cycles
    bus.ch_mask    = 8'b0001_0000;
    bus.continuous = 1'b1;
    bus.dwell      = 8'd1;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk_all($sformatf("mask1.c%0d", c), 3'd4, 1'b1, 1'b1, 1'b0,
              (c % 2 == 0) && (c != 0));
      step();
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_all("mask1.stop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
